// File: rtl/alu_ctrl_stage.sv
// Sequencing stage around the combinational ALU: latch op/operands, hold strobes for a settle window, capture result.
// Optional `ALU_CTRL_DIVZERO_EN: reject DIV with b_in == 0 in IDLE and pulse divzero instead of running the op.
module alu_ctrl_stage #(
  parameter int SETTLE_DEFAULT = 1,
  parameter int SETTLE_MULDIV  = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [13:0] alu_sel,
  input  logic [31:0] alu_chigh,
  input  logic [31:0] alu_clow,
  output logic [31:0] z_high,
  output logic [31:0] z_low,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        divzero
);

  // state  | meaning
  // IDLE   | waiting for start; alu_sel is zero
  // SETTLE | strobes and operands held; counter runs down to the capture edge
  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [3:0] LOAD_DEF = 4'(SETTLE_DEFAULT - 1);
  localparam logic [3:0] LOAD_MD  = 4'(SETTLE_MULDIV - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [13:0] dec_sel;
  logic        dz_hit;
  logic        accept, finish, reject_ill, reject_dz;

  always_comb begin
    dec_sel = '0;
    case (opcode)
      5'b00011: dec_sel = 14'h0001;
      5'b00100: dec_sel = 14'h0002;
      5'b01111: dec_sel = 14'h0004;
      5'b10000: dec_sel = 14'h0008;
      5'b01010: dec_sel = 14'h0010;
      5'b01011: dec_sel = 14'h0020;
      5'b00101: dec_sel = 14'h0040;
      5'b00110: dec_sel = 14'h0080;
      5'b00111: dec_sel = 14'h0100;
      5'b01000: dec_sel = 14'h0200;
      5'b01001: dec_sel = 14'h0400;
      5'b10001: dec_sel = 14'h0800;
      5'b10010: dec_sel = 14'h1000;
      5'b11111: dec_sel = 14'h2000;
      default:  dec_sel = '0;
    endcase
  end

`ifdef ALU_CTRL_DIVZERO_EN
  assign dz_hit = dec_sel[3] && (b_in == 32'd0);
`else
  assign dz_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    finish     = 1'b0;
    reject_ill = 1'b0;
    reject_dz  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (dec_sel == '0)  reject_ill = 1'b1;
          else if (dz_hit)    reject_dz  = 1'b1;
          else begin
            accept   = 1'b1;
            state_nx = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt     <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      z_high  <= '0;
      z_low   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      divzero <= 1'b0;
    end else begin
      done    <= finish;
      illegal <= reject_ill;
      divzero <= reject_dz;
      if (accept) begin
        alu_a   <= a_in;
        alu_b   <= b_in;
        alu_sel <= dec_sel;
        cnt     <= (dec_sel[2] || dec_sel[3]) ? LOAD_MD : LOAD_DEF;
      end else if (finish) begin
        z_high  <= alu_chigh;
        z_low   <= alu_clow;
        alu_sel <= '0;
      end else if (state == SETTLE) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: stimulus pushes expected responses, a negedge monitor pops and checks them.
module tb_alu_ctrl_stage;

  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHL = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01010, OP_OR = 5'b01011, OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000, OP_NEG = 5'b10001, OP_NOT = 5'b10010;
  localparam logic [4:0] OP_INC = 5'b11111;

  localparam int K_DONE = 0, K_ILL = 1, K_DZ = 2;

  typedef struct {
    int          kind;
    logic [13:0] sel;
    logic [31:0] zh;
    logic [31:0] zl;
    int          n;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [13:0] sel;
    logic [31:0] zh;
    logic [31:0] zl;
    int          n;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [31:0] alu_a, alu_b, alu_chigh, alu_clow, z_high, z_low;
  logic [13:0] alu_sel;
  logic        busy, done, illegal, divzero;

  int checks = 0;
  int errors = 0;
  int busy_run = 0;
  int done_seen = 0;
  int exp_dones = 0;
  logic [31:0] zh_prev = '0, zl_prev = '0;
  exp_t sb[$];
  vec_t vecs[10];

  alu_ctrl_stage dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode), .a_in(a_in), .b_in(b_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_chigh(alu_chigh), .alu_clow(alu_clow),
    .z_high(z_high), .z_low(z_low), .busy(busy), .done(done), .illegal(illegal), .divzero(divzero)
  );

  always #5 clk = ~clk;

  // behavioural stand-in for the external combinational ALU
  always_comb begin
    alu_chigh = '0;
    alu_clow  = '0;
    if (alu_sel[0]) alu_clow = alu_a + alu_b;
    if (alu_sel[1]) alu_clow = alu_a - alu_b;
    if (alu_sel[2]) {alu_chigh, alu_clow} = {32'd0, alu_a} * {32'd0, alu_b};
    if (alu_sel[3]) begin
      if (alu_b == 32'd0) begin
        alu_chigh = alu_a;
        alu_clow  = 32'hFFFF_FFFF;
      end else begin
        alu_chigh = alu_a % alu_b;
        alu_clow  = alu_a / alu_b;
      end
    end
    if (alu_sel[4])  alu_clow = alu_a & alu_b;
    if (alu_sel[5])  alu_clow = alu_a | alu_b;
    if (alu_sel[8])  alu_clow = alu_a << alu_b[4:0];
    if (alu_sel[11]) alu_clow = -alu_a;
    if (alu_sel[12]) alu_clow = ~alu_a;
    if (alu_sel[13]) alu_clow = alu_a + 32'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (busy) begin
        busy_run++;
        if (sb.size() == 0) check("busy_unexpected", 64'(busy), 64'd0);
        else                check("sel_settle", 64'(alu_sel), 64'(sb[0].sel));
      end else begin
        check("sel_idle", 64'(alu_sel), 64'd0);
      end
      if (!done) begin
        check("z_hold_high", 64'(z_high), 64'(zh_prev));
        check("z_hold_low", 64'(z_low), 64'(zl_prev));
      end
      if (done || illegal || divzero) begin
        check("pulse_overlap", 64'(int'(done) + int'(illegal) + int'(divzero)), 64'd1);
        if (sb.size() == 0) begin
          check("pulse_unexpected", {61'd0, done, illegal, divzero}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (done) begin
            done_seen++;
            check("kind_done", 64'(e.kind), 64'(K_DONE));
            check("z_high", 64'(z_high), 64'(e.zh));
            check("z_low", 64'(z_low), 64'(e.zl));
            check("busy_cycles", 64'(busy_run), 64'(e.n));
          end else if (illegal) begin
            check("kind_illegal", 64'(e.kind), 64'(K_ILL));
            check("busy_before_illegal", 64'(busy_run), 64'd0);
          end else begin
            check("kind_divzero", 64'(e.kind), 64'(K_DZ));
            check("busy_before_divzero", 64'(busy_run), 64'd0);
          end
          busy_run = 0;
        end
      end
    end else begin
      busy_run = 0;
    end
    zh_prev = z_high;
    zl_prev = z_low;
  end

  // called at posedge+1; start is sampled by the next edge, after which we return at that edge+1
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op;
    a_in   = a;
    b_in   = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push(input int kind, input logic [13:0] sel, input logic [31:0] zh,
                      input logic [31:0] zl, input int n);
    exp_t e;
    e.kind = kind; e.sel = sel; e.zh = zh; e.zl = zl; e.n = n;
    sb.push_back(e);
    if (kind == K_DONE) exp_dones++;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{OP_ADD, 32'd5,          32'd7,    14'h0001, 32'd0, 32'd12,         1};
    vecs[1] = '{OP_SUB, 32'd10,         32'd3,    14'h0002, 32'd0, 32'd7,          1};
    vecs[2] = '{OP_AND, 32'hF0,         32'h3C,   14'h0010, 32'd0, 32'h30,         1};
    vecs[3] = '{OP_OR,  32'hF0,         32'h0F,   14'h0020, 32'd0, 32'hFF,         1};
    vecs[4] = '{OP_SHL, 32'd1,          32'd4,    14'h0100, 32'd0, 32'd16,         1};
    vecs[5] = '{OP_NOT, 32'd0,          32'd0,    14'h1000, 32'd0, 32'hFFFF_FFFF,  1};
    vecs[6] = '{OP_NEG, 32'd1,          32'd0,    14'h0800, 32'd0, 32'hFFFF_FFFF,  1};
    vecs[7] = '{OP_INC, 32'h41,         32'd0,    14'h2000, 32'd0, 32'h42,         1};
    vecs[8] = '{OP_MUL, 32'hFFFF_FFFF,  32'd2,    14'h0004, 32'd1, 32'hFFFF_FFFE,  4};
    vecs[9] = '{OP_DIV, 32'd100,        32'd7,    14'h0008, 32'd2, 32'd14,         4};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sel", 64'(alu_sel), 64'd0);
    check("rst_z", {z_high, z_low}, 64'd0);
    check("rst_ab", {alu_a, alu_b}, 64'd0);
    check("rst_pulses", {61'd0, done, illegal, divzero}, 64'd0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back directed vectors: next start sampled while done is high
    for (int i = 0; i < 10; i++) begin
      push(K_DONE, vecs[i].sel, vecs[i].zh, vecs[i].zl, vecs[i].n);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      repeat (vecs[i].n) @(posedge clk);
      #1;
    end
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    push(K_ILL, 14'h0, 32'd0, 32'd0, 0);
    issue(5'b00000, 32'd9, 32'd9);
    repeat (2) @(posedge clk);
    #1;
    push(K_ILL, 14'h0, 32'd0, 32'd0, 0);
    issue(5'b11110, 32'd9, 32'd9);
    repeat (2) @(posedge clk);
    #1;
    check("illegal_ab_kept", {alu_a, alu_b}, {32'd100, 32'd7});

    // start during SETTLE is dropped
    push(K_DONE, 14'h0004, 32'd0, 32'd12, 4);
    issue(OP_MUL, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    issue(OP_AND, 32'hFF, 32'hFF);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // clear mid-SETTLE discards the DIV
    issue(OP_DIV, 32'd100, 32'd7);
    sb.push_back('{K_DONE, 14'h0008, 32'd0, 32'd0, 4});
    @(posedge clk);
    #2 clr = 1'b1;
    sb.delete();
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_sel", 64'(alu_sel), 64'd0);
    check("clr_z", {z_high, z_low}, 64'd0);
    check("clr_ab", {alu_a, alu_b}, 64'd0);
    check("clr_pulses", {61'd0, done, illegal, divzero}, 64'd0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    push(K_DONE, 14'h0001, 32'd0, 32'd2, 1);
    issue(OP_ADD, 32'd1, 32'd1);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

`ifdef ALU_CTRL_DIVZERO_EN
    push(K_DZ, 14'h0, 32'd0, 32'd0, 0);
`else
    push(K_DONE, 14'h0008, 32'd9, 32'hFFFF_FFFF, 4);
`endif
    issue(OP_DIV, 32'd9, 32'd0);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    check("sb_drained", 64'(sb.size()), 64'd0);
    check("done_count", 64'(done_seen), 64'(exp_dones));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Sequencing stage wrapped around the combinational ALU. It latches a 5-bit opcode and both operands on a start handshake, then drives the ALU's one-hot operation strobes and operands stably for a programmable settle window. It captures the ALU's 64-bit result (Chigh/Clow) into the Z-high/Z-low registers and signals completion. MUL and DIV get a longer multicycle window than the other operations.

## Interface
- SETTLE_DEFAULT, 1: settle cycles for all non-MUL/DIV ops; legal 1..15
- SETTLE_MULDIV, 4: settle cycles for MUL and DIV; legal 1..15
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only in IDLE
- opcode  in  5  operation code (see Operation)
- a_in, b_in  in  32 each  operands, sampled with start
- alu_a, alu_b  out  32 each  latched operands to ALU A/B
- alu_sel  out  14  one-hot strobe: bit0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT, 13 IncPC
- alu_chigh, alu_clow  in  32 each  ALU result halves
- z_high, z_low  out  32 each  captured result registers
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, result captured
- illegal  out  1  one-cycle pulse, unknown opcode rejected
- divzero  out  1  one-cycle pulse, DIV by zero trapped (see Configuration)

## Operation
- Opcode map:
  - ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111
  - ROR 01000, ROL 01001, AND 01010, OR 01011
  - MUL 01111, DIV 10000, NEG 10001, NOT 10010, IncPC 11111
  - All other codes are illegal.
- States: IDLE, SETTLE.
- IDLE, start=1, legal opcode:
  - latch a_in, b_in and the decoded one-hot select.
  - load counter with N−1, where N = SETTLE_MULDIV for MUL/DIV, else SETTLE_DEFAULT.
  - go to SETTLE.
- IDLE, start=1, illegal opcode: illegal=1 next cycle; stay IDLE; no register other than illegal changes.
- SETTLE, counter ≠ 0: decrement.
- SETTLE, counter = 0:
  - z_high←alu_chigh, z_low←alu_clow.
  - done=1; alu_sel←0; go to IDLE.
- alu_sel is all-zero in IDLE and exactly one-hot throughout SETTLE.
- alu_a and alu_b hold their last latched values in IDLE.
- start while busy is ignored, not queued.
- Z registers change only on a capture edge.
- Reset, asynchronous, at any time including mid-SETTLE:
  - state IDLE, counter 0.
  - alu_a, alu_b, alu_sel, z_high, z_low = 0.
  - busy, done, illegal, divzero = 0.
  - any in-flight operation is discarded.

## Timing
- start sampled at edge T:
  - busy=1 during cycles T..T+N.
  - capture, done=1 and busy=0 at edge T+N.
  - done remains high for exactly one cycle.
- N=1 gives capture one edge after acceptance.
- Back-to-back: a start sampled at edge T+N+1, while done is high, is accepted. Peak throughput is one op per N+1 cycles.
- illegal and divzero pulse for exactly one cycle after the rejecting edge and never overlap done.
- Counter is 4 bits. Parameters outside 1..15 are unsupported.

## Configuration
- ALU_CTRL_DIVZERO_EN defined:
  - DIV with b_in = 0 is rejected in IDLE: divzero pulses one cycle, no SETTLE, Z unchanged, alu_sel stays 0.
- Not defined:
  - divzero is tied 0.
  - DIV by zero runs the full SETTLE_MULDIV window and captures whatever the ALU produces.

## Test plan
- ADD, a=5, b=7, defaults, start at edge T -> alu_sel=0x0001 during SETTLE; edge T+1: z_low=12, z_high=0, one-cycle done pulse.
- MUL, a=0xFFFFFFFF, b=2, SETTLE_MULDIV=4 -> alu_sel=0x0004 stable for 4 cycles, busy high 4 cycles; edge T+4: z_high:z_low equals the ALU output, done pulse.
- opcode 00000 with start -> illegal pulse one cycle, busy never rises, Z unchanged, alu_sel=0.
- MUL accepted, start pulsed with AND two cycles later -> second start ignored; only the MUL result captured; one done pulse.
- clr asserted mid-SETTLE of DIV (a=100, b=7) -> all outputs 0 immediately; no done; next ADD 1+1 completes normally with z_low=2.
- DIV, b=0, with ALU_CTRL_DIVZERO_EN -> divzero pulse, no busy, Z unchanged. Without the macro -> busy for 4 cycles, then done.
